// File: rtl/chu_blink_pkg.sv
// Shared types and constants for the blink/burst GPO core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: MODE field encoding, channel FSM states, register word addresses,
//           STATUS / CFG field offsets.
package chu_blink_pkg;

    // MODE register field encoding; the unused code 2'b11 is treated as static.
    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_BURST  = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_STATIC = 2'b00,
        S_BLINK  = 2'b01,
        S_BURST  = 2'b10
    } state_t;

    localparam logic [4:0] A_DATA     = 5'd0;
    localparam logic [4:0] A_MODE     = 5'd1;
    localparam logic [4:0] A_STATUS   = 5'd2;
    localparam logic [4:0] A_CFG_BASE = 5'd8;

    localparam int ST_BUSY_LSB = 0;
    localparam int ST_DONE_LSB = 8;
    localparam int CFG_CNT_LSB = 16;

endpackage

// File: rtl/blink_channel.sv
// One output channel: static level, free-running blinker or counted pulse burst.
// Latency: out is registered; static level appears 1 clk after static_bit changes.
// Backpressure: none; mode_load is accepted every cycle and always wins.
// Ports: clk/reset; tick (prescaler pulse); mode + mode_load (new MODE field and
//        its load strobe); speed (half-period in ticks); count (burst pulses);
//        static_bit (DATA bit); out, busy, done_pulse (1-clk on burst completion).
module blink_channel
    import chu_blink_pkg::*;
#(
    parameter int SPD_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             mode_load,
    input  logic [SPD_W-1:0] speed,
    input  logic [7:0]       count,
    input  logic             static_bit,
    output logic             out,
    output logic             busy,
    output logic             done_pulse
);

    state_t           state;
    logic [SPD_W-1:0] cnt;
    logic             phase;
    logic             hold_low;   // burst finished: keep output low until next MODE load
    logic [8:0]       remaining;  // edges left in the burst (two per pulse)
    logic             wrap;

    // The comparison is >= so that shrinking speed mid-count wraps at the next tick.
    assign wrap = tick && (speed != '0) && (cnt >= speed - SPD_W'(1));
    assign busy = (state == S_BURST) && (remaining != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_STATIC;
            cnt        <= '0;
            phase      <= 1'b0;
            hold_low   <= 1'b0;
            remaining  <= '0;
            out        <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (mode_load) begin
                cnt       <= '0;
                phase     <= 1'b0;
                hold_low  <= 1'b0;
                remaining <= {count, 1'b0};
                if (mode == MODE_BLINK) begin
                    state <= S_BLINK;
                    out   <= 1'b0;
                end else if (mode == MODE_BURST) begin
                    state <= S_BURST;
                    out   <= 1'b0;
                end else begin
                    state <= S_STATIC;
                    out   <= static_bit;
                end
            end else begin
                case (state)
                    S_STATIC: begin
                        out <= static_bit & ~hold_low;
                    end
                    S_BLINK: begin
                        if (speed == '0) begin
                            cnt   <= '0;
                            phase <= 1'b0;
                            out   <= 1'b0;
                        end else if (wrap) begin
                            cnt   <= '0;
                            phase <= ~phase;
                            out   <= ~phase;
                        end else if (tick) begin
                            cnt <= cnt + SPD_W'(1);
                        end
                    end
                    S_BURST: begin
                        if (remaining == '0) begin
                            state      <= S_STATIC;
                            hold_low   <= 1'b1;
                            phase      <= 1'b0;
                            out        <= 1'b0;
                            done_pulse <= 1'b1;
                        end else if (wrap) begin
                            cnt       <= '0;
                            phase     <= ~phase;
                            out       <= ~phase;
                            remaining <= remaining - 9'd1;
                        end else if (tick && (speed != '0)) begin
                            cnt <= cnt + SPD_W'(1);
                        end
                    end
                    default: begin
                        state <= S_STATIC;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/chu_blink_gpo.sv
// MMIO GPO core: N channels of static / blink / burst output with shared tick prescaler.
// Latency: register writes take effect at the write edge; dout follows 1 clk later.
// Backpressure: none; slot accesses complete in a single cycle, reads are combinational.
// Ports: clk, reset (async, active-high); cs/read/write/addr/wr_data/rd_data slot bus;
//        dout[N-1:0] registered channel outputs.
module chu_blink_gpo
    import chu_blink_pkg::*;
#(
    parameter int N        = 4,
    parameter int TICK_DIV = 50000,
    parameter int SPD_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [N-1:0] dout
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic             we;
    logic             mode_wr;
    logic [N-1:0]     data_q;
    logic [2*N-1:0]   mode_q;
    logic [SPD_W-1:0] speed_q [N];
    logic [7:0]       count_q [N];
    logic [N-1:0]     done_q;
    logic [N-1:0]     done_clr;
    logic [N-1:0]     done_pulse;
    logic [N-1:0]     busy;
    logic [N-1:0]     mode_load;
    logic             unused_ok;

    // Reads have no side effects, so the read strobe and upper write bits go nowhere.
    assign unused_ok = ^{read, wr_data};

    assign we      = cs && write;
    assign mode_wr = we && (addr == A_MODE);
    assign tick    = (div_cnt == DW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign done_clr = (we && (addr == A_STATUS)) ? wr_data[ST_DONE_LSB +: N] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            mode_q <= '0;
            done_q <= '0;
            for (int i = 0; i < N; i++) begin
                speed_q[i] <= '0;
                count_q[i] <= '0;
            end
        end else begin
            if (we && (addr == A_DATA)) begin
                data_q <= wr_data[N-1:0];
            end
            if (mode_wr) begin
                mode_q <= wr_data[2*N-1:0];
            end
            for (int i = 0; i < N; i++) begin
                if (we && (addr == A_CFG_BASE + 5'(i))) begin
                    speed_q[i] <= wr_data[SPD_W-1:0];
                    count_q[i] <= wr_data[CFG_CNT_LSB +: 8];
                end
            end
            // A completion landing in the same cycle as its clear must not be lost.
            done_q <= (done_q & ~done_clr) | done_pulse;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        // Only a changed field restarts the channel, so firmware can rewrite MODE
        // for one channel without disturbing the others.
        assign mode_load[i] = mode_wr && (wr_data[2*i +: 2] != mode_q[2*i +: 2]);

        blink_channel #(
            .SPD_W(SPD_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .mode       (wr_data[2*i +: 2]),
            .mode_load  (mode_load[i]),
            .speed      (speed_q[i]),
            .count      (count_q[i]),
            .static_bit (data_q[i]),
            .out        (dout[i]),
            .busy       (busy[i]),
            .done_pulse (done_pulse[i])
        );
    end

    always_comb begin
        rd_data = '0;
        if (addr == A_DATA) begin
            rd_data[N-1:0] = data_q;
        end else if (addr == A_MODE) begin
            rd_data[2*N-1:0] = mode_q;
        end else if (addr == A_STATUS) begin
            rd_data[ST_BUSY_LSB +: N] = busy;
            rd_data[ST_DONE_LSB +: N] = done_q;
        end
        for (int i = 0; i < N; i++) begin
            if (addr == A_CFG_BASE + 5'(i)) begin
                rd_data[SPD_W-1:0]        = speed_q[i];
                rd_data[CFG_CNT_LSB +: 8] = count_q[i];
            end
        end
    end

endmodule

// File: tb/tb_chu_blink_gpo.sv
// Bench for chu_blink_gpo: directed register/output checks through a scoreboard queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_chu_blink_gpo;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [3:0]  dout;

    chu_blink_gpo #(
        .N        (4),
        .TICK_DIV (4),
        .SPD_W    (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard queues: sample checks (kind 0 rd_data, 1 dout, 2 rise count)
    // and expected run lengths of one watched dout bit.
    bit [1:0]    ck_kind_q [$];
    logic [31:0] ck_mask_q [$];
    logic [31:0] ck_exp_q  [$];
    string       ck_name_q [$];
    int          run_lvl_q [$];
    int          run_len_q [$];

    int    total = 0;
    int    bad   = 0;
    bit    smp_vld  = 1'b0;
    bit    tmo_pend = 1'b0;
    string tmo_name = "";
    bit    run_en   = 1'b0;
    int    run_bit  = 0;

    bit [1:0]    mk;
    logic [31:0] mm, me, act;
    string       mn;
    bit          run_armed, run_started, run_cur;
    int          run_len_cur, rise_cnt, el, en;

    always @(negedge clk) begin
        if (smp_vld) begin
            total++;
            if (ck_exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: sample strobe with empty queue");
            end else begin
                mk = ck_kind_q.pop_front();
                mm = ck_mask_q.pop_front();
                me = ck_exp_q.pop_front();
                mn = ck_name_q.pop_front();
                case (mk)
                    2'd0:    act = rd_data;
                    2'd1:    act = 32'(dout);
                    default: act = 32'(rise_cnt);
                endcase
                if ((act & mm) != me) begin
                    bad++;
                    $display("FAIL %s: got 0x%08h want 0x%08h", mn, act & mm, me);
                end
            end
        end
        if (tmo_pend) begin
            total++;
            bad++;
            $display("FAIL %s: wait budget expired", tmo_name);
        end
        if (!run_en) begin
            run_armed = 1'b0;
        end else if (!run_armed) begin
            run_armed   = 1'b1;
            run_started = 1'b0;
            run_cur     = dout[run_bit];
            run_len_cur = 0;
            rise_cnt    = 0;
        end else if (dout[run_bit] != run_cur) begin
            if (dout[run_bit]) rise_cnt++;
            if (run_started && run_len_q.size() != 0) begin
                el = run_lvl_q.pop_front();
                en = run_len_q.pop_front();
                total++;
                if ((int'(run_cur) != el) || (run_len_cur != en)) begin
                    bad++;
                    $display("FAIL run dout[%0d]: got level %0d for %0d clk want level %0d for %0d clk",
                             run_bit, run_cur, run_len_cur, el, en);
                end
            end
            run_started = 1'b1;
            run_cur     = dout[run_bit];
            run_len_cur = 1;
        end else begin
            run_len_cur++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic chk(input bit [1:0] k, input logic [4:0] a, input logic [31:0] m,
                       input logic [31:0] e, input string nm);
        addr = a;
        ck_kind_q.push_back(k);
        ck_mask_q.push_back(m);
        ck_exp_q.push_back(e);
        ck_name_q.push_back(nm);
        smp_vld = 1'b1;
        @(negedge clk);
        #1;
        smp_vld = 1'b0;
    endtask

    task automatic flag_tmo(input string nm);
        tmo_name = nm;
        tmo_pend = 1'b1;
        @(negedge clk);
        #1;
        tmo_pend = 1'b0;
    endtask

    task automatic wait_bit(input int b, input logic lvl, input int budget, input string nm);
        int n = 0;
        while ((dout[b] !== lvl) && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (dout[b] !== lvl) flag_tmo(nm);
    endtask

    task automatic wait_runs(input int budget, input string nm);
        int n = 0;
        while ((run_len_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (run_len_q.size() != 0) flag_tmo(nm);
    endtask

    task automatic push_run(input int lvl, input int len);
        run_lvl_q.push_back(lvl);
        run_len_q.push_back(len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0;
        step(3);
        chk(2'd1, 5'd0, 32'hF, 32'h0, "reset_dout");
        chk(2'd0, 5'd0, 32'hFFFFFFFF, 32'h0, "reset_data");
        chk(2'd0, 5'd1, 32'hFFFFFFFF, 32'h0, "reset_mode");
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h0, "reset_status");
        chk(2'd0, 5'd8, 32'hFFFFFFFF, 32'h0, "reset_cfg0");
        step(1);
        reset = 1'b0;
        step(2);

        // Static levels and undefined-address handling.
        wr(5'd0, 32'hA);
        step(1);
        chk(2'd1, 5'd0, 32'hF, 32'hA, "data_dout");
        chk(2'd0, 5'd0, 32'hFFFFFFFF, 32'hA, "data_rd");
        wr(5'd5, 32'hFFFFFFFF);
        chk(2'd0, 5'd5, 32'hFFFFFFFF, 32'h0, "undef_rd");
        chk(2'd0, 5'd0, 32'hFFFFFFFF, 32'hA, "data_kept");

        // Blink ch0: speed 3 ticks of 4 clk -> 12 clk half-period.
        wr(5'd8, 32'h3);
        run_bit = 0;
        push_run(1, 12); push_run(0, 12); push_run(1, 12);
        run_en = 1'b1;
        wr(5'd1, 32'h1);
        wait_runs(200, "blink_runs");
        run_en = 1'b0;
        chk(2'd1, 5'd0, 32'hE, 32'hA, "blink_others");
        chk(2'd0, 5'd1, 32'hFFFFFFFF, 32'h1, "mode_rd");

        // Burst ch1: 2 pulses, 1 tick per half-period.
        wr(5'd0, 32'h8);
        wr(5'd9, 32'h00020001);
        chk(2'd0, 5'd9, 32'hFFFFFFFF, 32'h00020001, "cfg1_rd");
        run_bit = 1;
        push_run(1, 4); push_run(0, 4); push_run(1, 4);
        run_en = 1'b1;
        step(1);
        wr(5'd1, 32'h9);
        wait_bit(1, 1'b1, 20, "burst_start");
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h2, "burst_busy");
        wait_runs(100, "burst_runs");
        step(40);
        chk(2'd2, 5'd0, 32'hFFFFFFFF, 32'd2, "burst_pulses");
        chk(2'd1, 5'd0, 32'h2, 32'h0, "burst_low");
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h200, "done_set");
        run_en = 1'b0;
        wr(5'd2, 32'h200);
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h0, "done_w1c");

        // Finished burst keeps ch1 low even though DATA[1] is now 1.
        wr(5'd0, 32'hE);
        step(1);
        chk(2'd1, 5'd0, 32'h2, 32'h0, "hold_low");

        // Burst ch2 of 5 pulses, aborted after the first one.
        wr(5'd10, 32'h00050001);
        wr(5'd1, 32'h29);
        wait_bit(2, 1'b1, 20, "abort_rise");
        wait_bit(2, 1'b0, 20, "abort_fall");
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h4, "abort_busy");
        wr(5'd1, 32'h9);
        step(1);
        chk(2'd1, 5'd0, 32'hE, 32'hC, "abort_dout");
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h0, "abort_status");
        step(60);
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h0, "abort_no_done");

        // Asynchronous reset while ch0 is high.
        wait_bit(0, 1'b1, 40, "blink_high");
        #2;
        reset = 1'b1;
        chk(2'd1, 5'd0, 32'hF, 32'h0, "reset_async_dout");
        step(1);
        reset = 1'b0;
        step(2);
        chk(2'd0, 5'd0, 32'hFFFFFFFF, 32'h0, "post_reset_data");
        chk(2'd0, 5'd1, 32'hFFFFFFFF, 32'h0, "post_reset_mode");
        chk(2'd0, 5'd2, 32'hFFFFFFFF, 32'h0, "post_reset_status");
        chk(2'd0, 5'd8, 32'hFFFFFFFF, 32'h0, "post_reset_cfg0");
        chk(2'd1, 5'd0, 32'hF, 32'h0, "post_reset_dout");

        step(2);
        if ((ck_exp_q.size() != 0) || (run_len_q.size() != 0)) flag_tmo("queue_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
